spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- Downstream SPI receiver consuming the serial stream (cs, mosi) from the 64-bit SPI master in the same sclk_m domain.
- Deserialises each 64-bit MSB-first frame into a parallel word and buffers it in a 2-entry FIFO with a valid/ready handshake to the consumer.
- Drives miso with a 64-bit response word latched at frame start.
- Flags overflow and short (truncated) frames with sticky error bits.

Parameters:
- WORD_W, 64, frame length in bits and width of rx_data/tx_data.
- BIT_CYCLES, 2, sclk_m cycles per serial bit-time (must be >= 1).
- SAMPLE_PHASE, 1, phase within the bit-time at which mosi is sampled (0..BIT_CYCLES-1).

Ports:
- sclk_m  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  chip select from master, active-low.
- mosi  input  1  serial data from master, MSB first.
- miso  output  1  serial response to master, MSB first.
- tx_data  input  WORD_W  response word, captured on cs falling edge.
- rx_data  output  WORD_W  head-of-FIFO received word.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
- bit_count  output  7  bits sampled in current frame (0..64).
- busy  output  1  high while a frame is in progress (state SHIFT or WAIT_CS).
- overflow  output  1  sticky: completed word dropped because FIFO full.
- frame_err  output  1  sticky: cs rose before WORD_W bits were sampled.
- clr_err  input  1  synchronous clear of overflow and frame_err.

Behaviour:
- Reset (async, active-high): miso=0, rx_valid=0, rx_data=0, bit_count=0, busy=0, overflow=0, frame_err=0, FIFO empty, state IDLE, cs_q=1.
- cs_q is the registered copy of cs. Frame start is the cycle with cs_q=1 & cs=0.
- States:
  - IDLE: waits for frame start. On frame start: go to SHIFT, phase=0, bit_count=0, shift register cleared, tx_data latched into tx_shift.
  - SHIFT: phase counts 0..BIT_CYCLES-1 and wraps. When phase==SAMPLE_PHASE: shift_reg <= {shift_reg[WORD_W-2:0], mosi} and bit_count increments. When the WORD_W-th bit is sampled: the word is pushed to the FIFO in the same edge (rx_valid high the next cycle if it was empty), then go to WAIT_CS.
  - WAIT_CS: further mosi bits are ignored and bit_count holds 64. On cs=1, return to IDLE.
- Frame gap: cs must be high at least 1 cycle between frames. cs low continuously never starts a second frame.
- Early cs rise in SHIFT (bit_count < WORD_W): partial word discarded, frame_err <= 1, state <= IDLE, bit_count <= 0.
- miso:
  - 0 in IDLE.
  - In SHIFT, miso = tx_shift[WORD_W-1], registered.
  - tx_shift shifts left by 1 at phase 0 of each bit-time after the first, so bit k is driven for bit-time k.
  - In WAIT_CS, miso = 0.
- FIFO:
  - 2 entries. rx_data shows the head entry and is stable while rx_valid & !rx_ready.
  - Pop on rx_valid & rx_ready.
  - Push and pop in the same cycle are both performed, with occupancy unchanged.
  - Push when full with no simultaneous pop: word dropped, overflow <= 1.
  - Push when full with a simultaneous pop: accepted, no overflow.
- Errors: overflow and frame_err stay set until clr_err=1. If clr_err and a new error event occur in the same cycle, the set wins.
- Reset mid-frame: all state cleared immediately. The frame is lost and no error is flagged.
- bit_count returns to 0 in IDLE.

Test Plan:
- Single frame: send 64'hDEAD_BEEF_0123_4567 with BIT_CYCLES=2 and rx_ready=1 -> rx_valid pulses 1 cycle, rx_data=64'hDEAD_BEEF_0123_4567, bit_count reaches 64, overflow=0, frame_err=0.
- Response path: tx_data=64'hA5A5_0000_FFFF_8001 at cs fall -> miso sequence captured at SAMPLE_PHASE equals 64'hA5A5_0000_FFFF_8001 MSB first. miso=0 before cs fall and after bit 64.
- Back-pressure/overflow: rx_ready=0, send frames 1, 2, 3 (values 1, 2, 3) -> FIFO holds 1 then 2, overflow=1 after frame 3. Then rx_ready=1 -> outputs 1, 2, then rx_valid=0. clr_err -> overflow=0.
- Truncated frame: cs rises after 20 bits -> frame_err=1, FIFO unchanged, bit_count=0. Next full frame 64'h1 is received correctly.
- Simultaneous push/pop: FIFO full with rx_ready=1 in the completion cycle of a frame carrying 64'h3 -> no overflow, occupancy stays 2, order preserved.
- Async reset asserted at bit 30 -> all outputs 0 immediately. A subsequent 64'hFFFF_FFFF_FFFF_FFFF frame is received intact.

Source files
------------

// File: rtl/spi_slave_rx_if.sv
// Signal bundle between the SPI receiver, the serial master pins and the
// parallel consumer of received words.
interface spi_slave_rx_if #(
    parameter int WORD_W = 64
);
    // Serial side
    logic              cs;
    logic              mosi;
    logic              miso;
    logic [WORD_W-1:0] tx_data;

    // Parallel consumer side
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    // Status and error control
    logic [6:0]        bit_count;
    logic              busy;
    logic              overflow;
    logic              frame_err;
    logic              clr_err;

    // Receiver side of the bundle
    modport slave (
        input  cs,
        input  mosi,
        input  tx_data,
        input  rx_ready,
        input  clr_err,
        output miso,
        output rx_data,
        output rx_valid,
        output bit_count,
        output busy,
        output overflow,
        output frame_err
    );

    // Driving side of the bundle (SPI master plus word consumer)
    modport master (
        output cs,
        output mosi,
        output tx_data,
        output rx_ready,
        output clr_err,
        input  miso,
        input  rx_data,
        input  rx_valid,
        input  bit_count,
        input  busy,
        input  overflow,
        input  frame_err
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI receiver in the master's sclk_m domain: deserialises MSB-first frames
// of WORD_W bits into a 2-entry FIFO, returns a response word on miso that
// is captured at frame start, and keeps sticky overflow / short-frame flags.
module spi_slave_rx #(
    parameter int WORD_W       = 64,
    parameter int BIT_CYCLES   = 2,
    parameter int SAMPLE_PHASE = 1
) (
    input  logic          sclk_m,
    input  logic          reset,
    spi_slave_rx_if.slave bus
);

    localparam int              PH_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(BIT_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);
    localparam logic [6:0]      CNT_LAST  = 7'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } state_e;

    // Frame control
    state_e            state_q, state_d;
    logic              cs_q;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [6:0]        bit_count_q, bit_count_d;

    // Receive and response shifters; the last received bit comes straight
    // from mosi, so the receive shifter only holds the first WORD_W-1 bits.
    logic [WORD_W-2:0] shift_q, shift_d;
    logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
    logic              miso_q, miso_d;

    // Two-entry receive FIFO
    logic [WORD_W-1:0] fifo_q [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    // Sticky error flags
    logic              overflow_q, overflow_d;
    logic              frame_err_q, frame_err_d;

    // Decoded events
    logic              frame_start;
    logic              sample_en;
    logic              last_bit;
    logic              short_frame;
    logic [WORD_W-1:0] push_word;
    logic              pop;
    logic              fifo_full;
    logic              accept;
    logic              overflow_set;

    // A frame starts on the first low cycle of cs after it was seen high.
    assign frame_start  = cs_q & ~bus.cs;
    assign sample_en    = (state_q == SHIFT) & ~bus.cs & (phase_q == PH_SAMPLE);
    assign last_bit     = sample_en & (bit_count_q == CNT_LAST);
    // cs rising while still shifting means fewer than WORD_W bits arrived.
    assign short_frame  = (state_q == SHIFT) & bus.cs;
    assign push_word    = {shift_q, bus.mosi};

    assign pop          = (count_q != 2'd0) & bus.rx_ready;
    assign fifo_full    = (count_q == 2'd2);
    // A full FIFO still takes a word if the head leaves in the same cycle.
    assign accept       = last_bit & (~fifo_full | pop);
    assign overflow_set = last_bit & fifo_full & ~pop;

    // FSM state register and registered copy of cs
    always_ff @(posedge sclk_m or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (reset) begin
            state_q <= IDLE;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cs_q    <= bus.cs;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = SHIFT;
            end
            SHIFT: begin
                if (short_frame)   state_d = IDLE;
                else if (last_bit) state_d = WAIT_CS;
            end
            WAIT_CS: begin
                if (bus.cs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode: phase, bit counter, shifters and next miso value
    always_comb begin
        // NOTE: every variable gets a hold default up front so no path
        // through the case leaves it unassigned and infers a latch.
        phase_d     = phase_q;
        bit_count_d = bit_count_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        case (state_q)
            IDLE: begin
                bit_count_d = '0;
                if (frame_start) begin
                    phase_d    = '0;
                    shift_d    = '0;
                    tx_shift_d = bus.tx_data;
                end
            end
            SHIFT: begin
                if (bus.cs) begin
                    bit_count_d = '0;
                end else begin
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                    // Advance the response at each bit-time boundary so bit k
                    // is on miso for the whole of bit-time k.
                    if (phase_q == PH_LAST) begin
                        tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
                    end
                    if (sample_en) begin
                        shift_d     = {shift_q[WORD_W-3:0], bus.mosi};
                        bit_count_d = bit_count_q + 7'd1;
                    end
                end
            end
            WAIT_CS: begin
                if (bus.cs) bit_count_d = '0;
            end
            default: bit_count_d = '0;
        endcase
        miso_d = (state_d == SHIFT) ? tx_shift_d[WORD_W-1] : 1'b0;
    end

    // Frame datapath registers
    always_ff @(posedge sclk_m or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            bit_count_q <= '0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            bit_count_q <= bit_count_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
        end
    end

    // FIFO pointer/occupancy and sticky error next-state
    always_comb begin
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = accept ? ~wr_ptr_q : wr_ptr_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Clear first, then set, so a coincident new error wins.
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        if (bus.clr_err) begin
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end
        if (overflow_set) overflow_d  = 1'b1;
        if (short_frame)  frame_err_d = 1'b1;
    end

    // FIFO storage, pointers and error flags
    always_ff @(posedge sclk_m or posedge reset) begin
        // NOTE: the two storage words are reset because rx_data is visible
        // straight from the head entry and must read zero after reset.
        if (reset) begin
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (accept) fifo_q[wr_ptr_q] <= push_word;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.rx_data   = fifo_q[rd_ptr_q];
    assign bus.rx_valid  = (count_q != 2'd0);
    assign bus.bit_count = bit_count_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: a table of directed frames, a reset
// corner case and randomized traffic, all checked against a word-level
// reference (bounded queue plus sticky flags) kept in the bench.
`timescale 1ns/1ps
module tb_spi_slave_rx;

    localparam int W  = 64;
    localparam int BC = 2;
    localparam int SP = 1;

    logic sclk_m = 1'b0;
    logic reset;

    spi_slave_rx_if #(.WORD_W(W)) bus ();

    spi_slave_rx #(
        .WORD_W      (W),
        .BIT_CYCLES  (BC),
        .SAMPLE_PHASE(SP)
    ) dut (
        .sclk_m(sclk_m),
        .reset (reset),
        .bus   (bus)
    );

    always #5 sclk_m = ~sclk_m;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: received words waiting for the consumer, sticky flags.
    logic [W-1:0] mq[$];
    logic [W-1:0] got[$];
    bit           m_ovf;
    bit           m_ferr;
    bit           rnd_mode;
    logic         m_dummy;

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] tx;
        int           nbits;
        bit           rdy;
        bit           rdy_end;
        bit           clr_before;
        bit           exp_valid;
        logic [W-1:0] exp_head;
        bit           exp_ovf;
        bit           exp_ferr;
        int           n_drain;
        logic [W-1:0] drain0;
        logic [W-1:0] drain1;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the
    // model by what the coming rising edge does (pop, clear, push, error).
    task automatic cycle(input bit push, input logic [W-1:0] w, input bit ferr_ev,
                         output logic miso_s);
        int occ;
        bit pop;
        if (rnd_mode) begin
            bus.rx_ready = 1'($urandom_range(0, 1));
            bus.clr_err  = ($urandom_range(0, 7) == 0);
        end
        @(negedge sclk_m);
        miso_s = bus.miso;
        check("rx_valid", 64'(bus.rx_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) check("rx_data", bus.rx_data, mq[0]);
        check("overflow", 64'(bus.overflow), 64'(m_ovf));
        check("frame_err", 64'(bus.frame_err), 64'(m_ferr));
        occ = mq.size();
        pop = (occ > 0) && bus.rx_ready;
        if (pop) begin
            got.push_back(bus.rx_data);
            void'(mq.pop_front());
        end
        if (bus.clr_err) begin
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end
        if (push) begin
            if (occ < 2 || pop) mq.push_back(w);
            else                m_ovf = 1'b1;
        end
        if (ferr_ev) m_ferr = 1'b1;
        @(posedge sclk_m);
        #1;
    endtask

    // Master side of one frame. nbits < W truncates the frame; hold_cs
    // leaves cs low after the sent bits and returns without ending it.
    task automatic send_frame(input logic [W-1:0] data, input logic [W-1:0] tx,
                              input int nbits, input bit rdy, input bit rdy_end,
                              input bit hold_cs);
        logic [W-1:0] mword;
        logic         m;
        bit           last;
        mword = '0;
        check("miso_before_cs", 64'(bus.miso), 64'd0);
        bus.tx_data  = tx;
        bus.cs       = 1'b0;
        bus.mosi     = data[W-1];
        bus.rx_ready = rdy;
        cycle(1'b0, '0, 1'b0, m);
        // Changing tx_data after the start edge must not reach miso.
        bus.tx_data = ~tx;
        for (int k = 0; k < nbits; k++) begin
            bus.mosi = data[W-1-k];
            for (int p = 0; p < BC; p++) begin
                last = (k == W - 1) && (p == SP);
                bus.rx_ready = last ? rdy_end : rdy;
                cycle(last, data, 1'b0, m);
                if (p == SP) mword[W-1-k] = m;
            end
        end
        bus.rx_ready = rdy;
        if (hold_cs) return;
        if (nbits == W) begin
            check("bit_count_full", 64'(bus.bit_count), 64'd64);
            check("busy_wait_cs", 64'(bus.busy), 64'd1);
            check("miso_after_last", 64'(bus.miso), 64'd0);
            check("miso_word", mword, tx);
            bus.cs = 1'b1;
            cycle(1'b0, '0, 1'b0, m);
        end else begin
            check("bit_count_partial", 64'(bus.bit_count), 64'(nbits));
            check("busy_shift", 64'(bus.busy), 64'd1);
            bus.cs = 1'b1;
            cycle(1'b0, '0, 1'b1, m);
        end
        check("bit_count_idle", 64'(bus.bit_count), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("miso_idle", 64'(bus.miso), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_miso"},      64'(bus.miso),      64'd0);
        check({tag, "_rx_valid"},  64'(bus.rx_valid),  64'd0);
        check({tag, "_rx_data"},   bus.rx_data,        64'd0);
        check({tag, "_bit_count"}, 64'(bus.bit_count), 64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_overflow"},  64'(bus.overflow),  64'd0);
        check({tag, "_frame_err"}, 64'(bus.frame_err), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] rd, rt;
        int           nb;

        //            data                    tx                      nb  rdy   rend  clr   val   head   ovf   ferr  nd  d0     d1
        vecs[0] = '{64'hDEAD_BEEF_0123_4567, 64'hA5A5_0000_FFFF_8001, 64, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 0, 64'h0, 64'h0};
        vecs[1] = '{64'h1, 64'h0123_4567_89AB_CDEF,                   64, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0, 0, 64'h0, 64'h0};
        vecs[2] = '{64'h2, 64'hFFFF_FFFF_FFFF_FFFF,                   64, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0, 0, 64'h0, 64'h0};
        vecs[3] = '{64'h3, 64'h8000_0000_0000_0001,                   64, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 1'b1, 1'b0, 2, 64'h1, 64'h2};
        vecs[4] = '{64'hCAFE_F00D_1234_5678, 64'h5A5A_5A5A_5A5A_5A5A, 20, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 0, 64'h0, 64'h0};
        vecs[5] = '{64'h1, 64'h0F0F_0F0F_0F0F_0F0F,                   64, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b1, 0, 64'h0, 64'h0};
        vecs[6] = '{64'h2, 64'h3C3C_C3C3_3C3C_C3C3,                   64, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1, 1'b0, 1'b0, 0, 64'h0, 64'h0};
        vecs[7] = '{64'h3, 64'h1111_2222_3333_4444,                   64, 1'b0, 1'b1, 1'b0, 1'b1, 64'h2, 1'b0, 1'b0, 2, 64'h2, 64'h3};

        reset        = 1'b1;
        bus.cs       = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ready = 1'b0;
        bus.clr_err  = 1'b0;
        rnd_mode     = 1'b0;
        m_ovf        = 1'b0;
        m_ferr       = 1'b0;

        #2;
        check_all_zero("reset");
        repeat (2) @(posedge sclk_m);
        #1;
        reset = 1'b0;
        repeat (2) cycle(1'b0, '0, 1'b0, m_dummy);

        // Directed frames
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].clr_before) begin
                bus.clr_err = 1'b1;
                cycle(1'b0, '0, 1'b0, m_dummy);
                bus.clr_err = 1'b0;
            end
            send_frame(vecs[i].data, vecs[i].tx, vecs[i].nbits,
                       vecs[i].rdy, vecs[i].rdy_end, 1'b0);
            check($sformatf("v%0d_rx_valid", i), 64'(bus.rx_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check($sformatf("v%0d_rx_data", i), bus.rx_data, vecs[i].exp_head);
            check($sformatf("v%0d_overflow", i), 64'(bus.overflow), 64'(vecs[i].exp_ovf));
            check($sformatf("v%0d_frame_err", i), 64'(bus.frame_err), 64'(vecs[i].exp_ferr));
            if (vecs[i].n_drain > 0) begin
                got.delete();
                bus.rx_ready = 1'b1;
                repeat (3) cycle(1'b0, '0, 1'b0, m_dummy);
                bus.rx_ready = 1'b0;
                check($sformatf("v%0d_drain_count", i), 64'(got.size()), 64'(vecs[i].n_drain));
                check($sformatf("v%0d_drain0", i), (got.size() > 0) ? got[0] : 'x, vecs[i].drain0);
                check($sformatf("v%0d_drain1", i), (got.size() > 1) ? got[1] : 'x, vecs[i].drain1);
                check($sformatf("v%0d_drained", i), 64'(bus.rx_valid), 64'd0);
            end
        end

        // Reset in the middle of a frame while the FIFO holds a word
        send_frame(64'h77, 64'h0F0F_F0F0_0F0F_F0F0, 64, 1'b0, 1'b0, 1'b0);
        check("pre_reset_head", bus.rx_data, 64'h77);
        send_frame(64'h5555_AAAA_5555_AAAA, 64'hFFFF_0000_FFFF_0000, 30, 1'b0, 1'b0, 1'b1);
        check("pre_reset_bit_count", 64'(bus.bit_count), 64'd30);
        #2;
        reset  = 1'b1;
        bus.cs = 1'b1;
        #1;
        check_all_zero("midframe_reset");
        mq.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        @(negedge sclk_m);
        reset = 1'b0;
        @(posedge sclk_m);
        #1;
        cycle(1'b0, '0, 1'b0, m_dummy);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_0000_4567_0000, 64, 1'b0, 1'b0, 1'b0);
        check("post_reset_valid", 64'(bus.rx_valid), 64'd1);
        check("post_reset_data", bus.rx_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("post_reset_frame_err", 64'(bus.frame_err), 64'd0);
        bus.rx_ready = 1'b1;
        repeat (2) cycle(1'b0, '0, 1'b0, m_dummy);
        bus.rx_ready = 1'b0;

        // Randomized traffic: random words, truncations, back-pressure, clears
        rnd_mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rd = {$urandom(), $urandom()};
            rt = {$urandom(), $urandom()};
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 63)) : W;
            send_frame(rd, rt, nb, 1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) cycle(1'b0, '0, 1'b0, m_dummy);
        end
        rnd_mode     = 1'b0;
        bus.clr_err  = 1'b0;
        bus.rx_ready = 1'b1;
        repeat (3) cycle(1'b0, '0, 1'b0, m_dummy);
        check("final_empty", 64'(bus.rx_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
